// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file write-back arbiter.
//   REG_ADDR_W / DATA_W / NUM_REGS : register-file geometry
//   PORT_ALU / PORT_MEM            : bit index of each write-back port in the
//                                    request/grant vectors
//   port_e                         : identifies a write-back port
//   wb_req_t                       : address/data pair carried by a port
// ----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NUM_REGS   = 32;

   // One-bit indices so they select into the 2-bit request/grant vectors
   // without any width conversion.
   localparam logic PORT_ALU = 1'b0;
   localparam logic PORT_MEM = 1'b1;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester arbiter with a one-hot grant. With PRIO_FIXED=1, requester 0
// always wins a contention; with PRIO_FIXED=0, the requester not granted last
// wins. The grant is purely combinational from the requests and the pointer.
//   clk, reset : clock and synchronous active-high reset
//   i_req[1:0] : request vector (bit k = requester k)
//   o_grant    : one-hot grant, zero when nothing is requested
// ----------------------------------------------------------------------------
module rr_arbiter2
   import regfile_wb_arbiter_pkg::*;
#(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   output logic [1:0] o_grant
);

   port_e r_last;

   always_comb begin
      o_grant = '0;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11: begin
            if (PRIO_FIXED || (r_last == PORT1)) o_grant = 2'b01;
            else                                 o_grant = 2'b10;
         end
         default: o_grant = '0;
      endcase
   end

   // A grant always coincides with a handshake, since grant implies valid and
   // ready is the grant itself. Idle cycles leave the pointer untouched.
   // Resetting to "port 1 last" makes port 0 win the first contention.
   always_ff @(posedge clk) begin
      if (reset)           r_last <= PORT1;
      else if (o_grant[0]) r_last <= PORT0;
      else if (o_grant[1]) r_last <= PORT1;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates two write-back sources (ALU, memory load) onto a single
// register-file write port, and tracks outstanding destination reservations.
//   clk, reset         : clock, synchronous active-high reset
//   req0_*             : write-back port 0 (ALU): valid/ready/addr/data
//   req1_*             : write-back port 1 (memory load): valid/ready/addr/data
//   resv_valid/addr    : issue stage reserves a destination register
//   we3/a3/wd3         : registered register-file write port
//   pending            : bit n set while register n awaits write-back
//   unres_err          : sticky, a write retired to an unreserved register
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [REG_ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0]     req0_data,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [REG_ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0]     req1_data,
   input  logic                  resv_valid,
   input  logic [REG_ADDR_W-1:0] resv_addr,
   output logic                  we3,
   output logic [REG_ADDR_W-1:0] a3,
   output logic [DATA_W-1:0]     wd3,
   output logic [NUM_REGS-1:0]   pending,
   output logic                  unres_err
);

   logic [1:0]            w_req;
   logic [1:0]            w_grant;
   wb_req_t               w_sel;
   logic                  w_hs;
   logic                  w_wr;
   logic                  w_unres_hit;
   logic [NUM_REGS-1:0]   w_pending_nxt;

   logic                  r_we3;
   logic [REG_ADDR_W-1:0] r_a3;
   logic [DATA_W-1:0]     r_wd3;
   logic [NUM_REGS-1:0]   r_pending;
   logic                  r_unres_err;

   assign w_req[PORT_ALU] = req0_valid;
   assign w_req[PORT_MEM] = req1_valid;

   rr_arbiter2 #(
      .PRIO_FIXED (PRIO_FIXED)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_req   (w_req),
      .o_grant (w_grant)
   );

   // Ready is the grant itself and deliberately not gated by reset.
   assign req0_ready = w_grant[PORT_ALU];
   assign req1_ready = w_grant[PORT_MEM];

   always_comb begin
      w_sel = '{addr: req0_addr, data: req0_data};
      if (w_grant[PORT_MEM]) w_sel = '{addr: req1_addr, data: req1_data};
   end

   assign w_hs = |w_grant;
   // Writes to r0 are still accepted (handshake completes) but never reach
   // the register file.
   assign w_wr = w_hs && (w_sel.addr != '0);

   // Clear for the retiring write first, then the new reservation, so a
   // same-register set/clear on one edge leaves the bit set.
   always_comb begin
      w_pending_nxt = r_pending;
      if (r_we3) w_pending_nxt[r_a3] = 1'b0;
      if (resv_valid && (resv_addr != '0)) w_pending_nxt[resv_addr] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   assign w_unres_hit = r_we3 && !r_pending[r_a3];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we3       <= 1'b0;
         r_a3        <= '0;
         r_wd3       <= '0;
         r_pending   <= '0;
         r_unres_err <= 1'b0;
      end else begin
         r_we3     <= w_wr;
         if (w_wr) begin
            r_a3  <= w_sel.addr;
            r_wd3 <= w_sel.data;
         end
         r_pending <= w_pending_nxt;
         if (w_unres_hit) r_unres_err <= 1'b1;
      end
   end

   assign we3       = r_we3;
   assign a3        = r_a3;
   assign wd3       = r_wd3;
   assign pending   = r_pending;
   assign unres_err = r_unres_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter. Two instances share all inputs:
// u_rr (round-robin) and u_fx (port 0 fixed priority).
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid, req1_valid, resv_valid;
   logic [4:0]  req0_addr, req1_addr, resv_addr;
   logic [31:0] req0_data, req1_data;

   logic        rr_req0_ready, rr_req1_ready, rr_we3, rr_unres_err;
   logic [4:0]  rr_a3;
   logic [31:0] rr_wd3, rr_pending;
   logic        fx_req0_ready, fx_req1_ready, fx_we3, fx_unres_err;
   logic [4:0]  fx_a3;
   logic [31:0] fx_wd3, fx_pending;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .resv_valid(resv_valid), .resv_addr(resv_addr),
      .we3(rr_we3), .a3(rr_a3), .wd3(rr_wd3),
      .pending(rr_pending), .unres_err(rr_unres_err)
   );

   regfile_wb_arbiter #(.PRIO_FIXED(1'b1)) u_fx (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(fx_req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(fx_req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .resv_valid(resv_valid), .resv_addr(resv_addr),
      .we3(fx_we3), .a3(fx_a3), .wd3(fx_wd3),
      .pending(fx_pending), .unres_err(fx_unres_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

   // Contention vectors: port 0 / port 1 addresses per cycle.
   localparam logic [4:0] A0 [4] = '{5'd1, 5'd3, 5'd3, 5'd1};
   localparam logic [4:0] A1 [4] = '{5'd2, 5'd2, 5'd4, 5'd4};
   // Round-robin expectations: port-0 grant and retired address per cycle.
   localparam logic       RR_G0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   localparam logic [4:0] RR_A3 [4] = '{5'd1, 5'd2, 5'd3, 5'd4};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      resv_valid = 1'b0; resv_addr = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      do_reset();

      // Reset state
      chk("rst_we3",     {31'd0, rr_we3},       32'd0);
      chk("rst_a3",      {27'd0, rr_a3},        32'd0);
      chk("rst_wd3",     rr_wd3,                32'd0);
      chk("rst_pending", rr_pending,            32'd0);
      chk("rst_unres",   {31'd0, rr_unres_err}, 32'd0);

      // Reserve 5, write it back through port 0, retire
      resv_valid = 1'b1; resv_addr = 5'd5;
      @(negedge clk);
      idle_inputs();
      chk("resv5_pending", rr_pending, 32'h0000_0020);
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
      #1;
      chk("wb5_ready0", {31'd0, rr_req0_ready}, 32'd1);
      @(negedge clk);
      idle_inputs();
      chk("wb5_we3",     {31'd0, rr_we3}, 32'd1);
      chk("wb5_a3",      {27'd0, rr_a3},  32'd5);
      chk("wb5_wd3",     rr_wd3,          32'hDEAD_BEEF);
      chk("wb5_pend_hd", rr_pending,      32'h0000_0020);
      @(negedge clk);
      chk("wb5_we3_off", {31'd0, rr_we3},       32'd0);
      chk("wb5_pending", rr_pending,            32'd0);
      chk("wb5_unres",   {31'd0, rr_unres_err}, 32'd0);
      chk("wb5_a3_hold", {27'd0, rr_a3},        32'd5);
      chk("wb5_wd_hold", rr_wd3,                32'hDEAD_BEEF);

      // Contention: reserve 1..4, then both ports valid for four cycles
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         resv_valid = 1'b1; resv_addr = 5'(i);
         @(negedge clk);
      end
      idle_inputs();
      chk("resv14_rr", rr_pending, 32'h0000_001E);
      chk("resv14_fx", fx_pending, 32'h0000_001E);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            chk("b2b_we3", {31'd0, rr_we3}, 32'd1);
            chk("rr_a3",   {27'd0, rr_a3},  {27'd0, RR_A3[i-1]});
            chk("rr_wd3",  rr_wd3, (RR_G0[i-1] ? 32'hA0 : 32'hB0) | {27'd0, RR_A3[i-1]});
            chk("fx_a3",   {27'd0, fx_a3},  {27'd0, A0[i-1]});
         end
         req0_valid = 1'b1; req0_addr = A0[i]; req0_data = 32'hA0 | {27'd0, A0[i]};
         req1_valid = 1'b1; req1_addr = A1[i]; req1_data = 32'hB0 | {27'd0, A1[i]};
         #1;
         chk("rr_ready0", {31'd0, rr_req0_ready},  {31'd0, RR_G0[i]});
         chk("rr_ready1", {31'd0, rr_req1_ready},  {31'd0, ~RR_G0[i]});
         chk("fx_ready0", {31'd0, fx_req0_ready},  32'd1);
         chk("fx_ready1", {31'd0, fx_req1_ready},  32'd0);
         @(negedge clk);
      end
      idle_inputs();
      chk("b2b_we3_last", {31'd0, rr_we3}, 32'd1);
      chk("rr_a3_last",   {27'd0, rr_a3},  32'd4);
      chk("rr_wd3_last",  rr_wd3,          32'hB4);
      chk("fx_a3_last",   {27'd0, fx_a3},  32'd1);
      @(negedge clk);
      chk("cont_rr_we3",   {31'd0, rr_we3},       32'd0);
      chk("cont_rr_pend",  rr_pending,            32'd0);
      chk("cont_rr_unres", {31'd0, rr_unres_err}, 32'd0);
      chk("cont_fx_pend",  fx_pending,            32'h0000_0014);
      chk("cont_fx_unres", {31'd0, fx_unres_err}, 32'd1);

      // Write to r0 through port 1: accepted, suppressed
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
      #1;
      chk("r0_rr_ready1", {31'd0, rr_req1_ready}, 32'd1);
      chk("r0_fx_ready1", {31'd0, fx_req1_ready}, 32'd1);
      @(negedge clk);
      idle_inputs();
      chk("r0_we3",     {31'd0, rr_we3},       32'd0);
      chk("r0_pending", rr_pending,            32'd0);
      chk("r0_unres",   {31'd0, rr_unres_err}, 32'd0);
      chk("r0_a3_hold", {27'd0, rr_a3},        32'd4);
      chk("r0_wd_hold", rr_wd3,                32'hB4);
      chk("r0_fx_we3",  {31'd0, fx_we3},       32'd0);

      // Reserve 7; retire a write to 7 on the same edge as a new reserve of 7
      resv_valid = 1'b1; resv_addr = 5'd7;
      @(negedge clk);
      idle_inputs();
      chk("r7_pending", rr_pending, 32'h0000_0080);
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
      @(negedge clk);
      idle_inputs();
      chk("r7_we3", {31'd0, rr_we3}, 32'd1);
      chk("r7_a3",  {27'd0, rr_a3},  32'd7);
      resv_valid = 1'b1; resv_addr = 5'd7;
      @(negedge clk);
      idle_inputs();
      chk("r7_pend_kept", rr_pending,            32'h0000_0080);
      chk("r7_unres",     {31'd0, rr_unres_err}, 32'd0);

      // Write to 9, never reserved
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
      @(negedge clk);
      idle_inputs();
      chk("u9_we3",   {31'd0, rr_we3},       32'd1);
      chk("u9_a3",    {27'd0, rr_a3},        32'd9);
      chk("u9_unres0", {31'd0, rr_unres_err}, 32'd0);
      @(negedge clk);
      chk("u9_unres1", {31'd0, rr_unres_err}, 32'd1);
      chk("u9_we3_off", {31'd0, rr_we3},      32'd0);
      repeat (3) @(negedge clk);
      chk("u9_unres_sticky", {31'd0, rr_unres_err}, 32'd1);

      // Handshake in cycle N, reset in N+1 (with a handshake and reservation)
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0707;
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
      resv_valid = 1'b1; resv_addr = 5'd3;
      #1;
      chk("rst_ready1_ungated", {31'd0, rr_req1_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      chk("rstw_we3",     {31'd0, rr_we3},       32'd0);
      chk("rstw_a3",      {27'd0, rr_a3},        32'd0);
      chk("rstw_wd3",     rr_wd3,                32'd0);
      chk("rstw_pending", rr_pending,            32'd0);
      chk("rstw_unres",   {31'd0, rr_unres_err}, 32'd0);
      chk("rstw_fx_unres", {31'd0, fx_unres_err}, 32'd0);
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
      #1;
      chk("rstw_rr_ready0", {31'd0, rr_req0_ready}, 32'd1);
      chk("rstw_rr_ready1", {31'd0, rr_req1_ready}, 32'd0);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: PRIO_FIXED, 0, 0 = round-robin between write-back ports, 1 = port 0 always wins.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid  input  1 / req0_ready  output  1 / req0_addr  input  5 / req0_data  input  32; write-back port 0 (ALU).
REQ-005 SHALL have ports: req1_valid  input  1 / req1_ready  output  1 / req1_addr  input  5 / req1_data  input  32; write-back port 1 (memory load).
REQ-006 SHALL have ports: resv_valid  input  1 / resv_addr  input  5; issue stage reserves a destination register.
REQ-007 SHALL have ports: we3  output  1 / a3  output  5 / wd3  output  32; registered drive of the register-file write port.
REQ-008 SHALL have port: pending  output  32  scoreboard, bit n = register n awaiting write-back.
REQ-009 SHALL have port: unres_err  output  1  sticky, write-back to an unreserved register seen.

Function
REQ-010 SHALL compute grant combinationally: one valid -> that port; none -> no grant; both valid -> PRIO_FIXED=1: port 0; PRIO_FIXED=0: the port not granted last.
REQ-011 SHALL drive reqK_ready = grant to K; handshake = valid & ready; at most one handshake per cycle.
REQ-012 SHALL update the round-robin pointer only on a handshake; idle cycles leave it unchanged.
REQ-013 SHALL register the accepted request: the edge ending a handshake cycle loads a3/wd3 and sets we3=1 for exactly one cycle; 1-cycle latency; no handshake -> we3=0 next cycle, a3/wd3 hold.
REQ-014 SHALL accept a handshake to address 0 and keep we3=0, a3/wd3 unchanged (r0 write suppressed).
REQ-015 SHALL set pending[resv_addr] at the edge ending a cycle with resv_valid=1 and resv_addr!=0; pending[0] is constant 0.
REQ-016 SHALL clear pending[a3] at the edge ending a cycle with we3=1, i.e. the edge at which the register file captures the write.
REQ-017 SHALL, when a set and a clear target the same register on the same edge, leave the bit set (younger reservation wins).
REQ-018 SHALL set unres_err at the edge ending a cycle with we3=1 and pending[a3]=0; it stays set until reset.
REQ-019 SHALL allow back-to-back handshakes every cycle, sustaining one write per cycle with no bubbles.

Reset
REQ-020 SHALL on reset drive we3=0, a3=0, wd3=0, pending=0, unres_err=0, and set the round-robin pointer so that port 0 wins the first contention.
REQ-021 SHALL give reset priority over all inputs: a handshake or reservation in a reset cycle has no effect, and a write registered before reset is dropped (we3=0 after the reset edge).
REQ-022 SHALL keep reqK_ready combinational, without gating by reset.

Structure
REQ-023 SHALL place REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and the port-index constants (PORT_ALU=0, PORT_MEM=1) in a shared package.
REQ-024 SHALL implement grant and pointer logic in one sub-module, rr_arbiter2 (2 requests, fixed/round-robin parameter, 2-bit one-hot grant).
REQ-025 SHALL keep all scoreboard and write-port registers in regfile_wb_arbiter.

Verification
REQ-026 SHALL cover: resv addr 5 -> pending[5]=1; req0 addr 5, data 0xDEADBEEF -> next cycle we3=1, a3=5, wd3=0xDEADBEEF; edge after -> pending[5]=0, unres_err=0.
REQ-027 SHALL cover: both ports valid 4 cycles (addrs 1..4 reserved), PRIO_FIXED=0 -> grants 0,1,0,1; PRIO_FIXED=1 -> port 0 on all four cycles, req1_ready=0 throughout.
REQ-028 SHALL cover: req1 addr 0, data 0x1234 -> req1_ready=1, we3 stays 0, pending=0, unres_err=0.
REQ-029 SHALL cover: reserve 7, then a write to 7 and a new reserve of 7 retiring on the same edge -> pending[7] remains 1.
REQ-030 SHALL cover: write to addr 9 never reserved -> unres_err=1 one edge after we3 pulse, held until reset.
REQ-031 SHALL cover: handshake in cycle N, reset asserted in cycle N+1 -> we3=0 after reset edge, pending=0, next contention granted to port 0.
